// File: rtl/io_pkg.sv
// io_pkg: shared FSM encoding and address-map constants for the I/O bus bridge.
package io_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  localparam logic [7:0] IO_PAGE = 8'hFF;
  localparam int DEV_SLOT_W = 4;
  localparam logic [15:0] TIMEOUT_DATA = 16'hDEAD;
endpackage

// File: rtl/io_addr_decode.sv
// io_addr_decode: maps a CPU byte address to a device slot, mapped flag and one-hot enable.
module io_addr_decode
  import io_pkg::*;
#(
  parameter int NUM_DEV = 4
) (
  input  logic [15:0]           addr,
  output logic                  mapped,
  output logic [DEV_SLOT_W-1:0] sel,
  output logic [NUM_DEV-1:0]    onehot
);
  logic unused_low;
  assign unused_low = ^addr[3:0];
  assign sel = addr[7:4];
  assign mapped = addr[15:8] == IO_PAGE && 32'(sel) < NUM_DEV;
  assign onehot = mapped ? NUM_DEV'(1) << sel : '0;
endmodule

// File: rtl/io_bus_bridge.sv
// io_bus_bridge: d16 data port to peripheral bus bridge; IO_TIMEOUT_EN adds a WAIT-state timeout with cpu_err.
module io_bus_bridge
  import io_pkg::*;
#(
  parameter int NUM_DEV = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [15:0]            cpu_addr,
  input  logic [15:0]            cpu_wdata,
  output logic [15:0]            cpu_rdata,
  output logic                   cpu_ack,
  output logic                   cpu_busy,
  output logic                   cpu_err,
  output logic [NUM_DEV-1:0]     dev_en,
  output logic                   dev_wr_en,
  output logic [15:0]            dev_data,
  input  logic [16*NUM_DEV-1:0]  dev_rdata,
  input  logic [NUM_DEV-1:0]     dev_ready
);
  state_t state, nxt;
  logic mapped, we_q, ready_sel, timeout;
  logic [DEV_SLOT_W-1:0] unused_sel;
  logic [NUM_DEV-1:0] onehot, en_q;
  logic [15:0] rdata_q, rdata_sel;

  io_addr_decode #(.NUM_DEV(NUM_DEV)) u_dec (
    .addr(cpu_addr), .mapped(mapped), .sel(unused_sel), .onehot(onehot)
  );

  // The latched one-hot enable doubles as the read-mux and ready select.
  always_comb begin
    rdata_sel = '0;
    for (int i = 0; i < NUM_DEV; i++) rdata_sel |= en_q[i] ? dev_rdata[16*i +: 16] : 16'h0;
  end
  assign ready_sel = |(dev_ready & en_q);

`ifdef IO_TIMEOUT_EN
  logic [3:0] cnt;
  logic err_q;
  assign timeout = state == WAIT && !ready_sel && cnt == 4'(TIMEOUT - 1);
  always_ff @(posedge clk) begin
    cnt <= rst || state != WAIT ? '0 : cnt + 4'd1;
    err_q <= rst || state == IDLE ? 1'b0 : timeout ? 1'b1 : err_q;
  end
  assign cpu_err = cpu_ack & err_q;
`else
  localparam int unused_timeout = TIMEOUT;
  assign timeout = 1'b0;
  assign cpu_err = 1'b0;
`endif

  always_ff @(posedge clk) state <= rst ? IDLE : nxt;

  always_comb begin
    nxt = state;
    dev_en = '0;
    dev_wr_en = 1'b0;
    cpu_ack = 1'b0;
    cpu_rdata = '0;
    cpu_busy = state != IDLE;
    unique case (state)
      IDLE:  nxt = !cpu_req ? IDLE : mapped ? ISSUE : DONE;
      ISSUE: begin
        dev_en = en_q;
        dev_wr_en = we_q;
        nxt = ready_sel ? DONE : WAIT;
      end
      WAIT:  nxt = ready_sel || timeout ? DONE : WAIT;
      DONE:  begin
        nxt = IDLE;
        cpu_ack = 1'b1;
        cpu_rdata = rdata_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q <= 1'b0;
      en_q <= '0;
      dev_data <= '0;
      rdata_q <= '0;
    end else if (state == IDLE && cpu_req) begin
      we_q <= cpu_we;
      en_q <= onehot;
      dev_data <= cpu_wdata;
      rdata_q <= '0;
    end else if ((state == ISSUE || state == WAIT) && ready_sel) begin
      rdata_q <= we_q ? '0 : rdata_sel;
    end else if (timeout) begin
      rdata_q <= TIMEOUT_DATA;
    end
  end
endmodule

// File: tb/tb_io_bus_bridge.sv
// tb_io_bus_bridge: scoreboard bench for io_bus_bridge; set IO_TIMEOUT_EN to match the RTL build.
module tb_io_bus_bridge;
  localparam int N = 4;
  typedef struct packed {logic [15:0] d; logic e;} exp_t;

  logic clk = 0, rst = 1, cpu_req = 0, cpu_we = 0;
  logic [15:0] cpu_addr = '0, cpu_wdata = '0;
  logic [15:0] cpu_rdata, dev_data;
  logic cpu_ack, cpu_busy, cpu_err, dev_wr_en;
  logic [N-1:0] dev_en;
  logic [N-1:0] dev_ready = 4'b1001;
  logic [16*N-1:0] dev_rdata;
  logic [15:0] regs [N];
  int errors = 0, checks = 0, acks = 0, exp_acks = 0;
  exp_t sb[$];

  io_bus_bridge #(.NUM_DEV(N), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_busy(cpu_busy),
    .cpu_err(cpu_err), .dev_en(dev_en), .dev_wr_en(dev_wr_en), .dev_data(dev_data),
    .dev_rdata(dev_rdata), .dev_ready(dev_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  for (genvar g = 0; g < N; g++) assign dev_rdata[16*g +: 16] = regs[g];

  always @(posedge clk)
    if (rst) begin
      regs[0] <= 16'h0000;
      regs[1] <= 16'h1234;
      regs[2] <= 16'h5555;
      regs[3] <= 16'h0F0F;
    end else for (int i = 0; i < N; i++) if (dev_wr_en && dev_en[i]) regs[i] <= dev_data;

  always @(negedge clk) begin : mon
    exp_t e;
    if (dev_en != 0) check("onehot", 32'($onehot(dev_en)), 1);
    if (cpu_ack) begin
      acks++;
      if (sb.size() == 0) check("sb_empty", 1, 0);
      else begin
        e = sb.pop_front();
        check("rdata", cpu_rdata, e.d);
        check("err", cpu_err, e.e);
      end
    end else if (cpu_busy) check("rdata_idle0", cpu_rdata, 0);
  end

  task automatic access(input string n, input logic we, input logic [15:0] a, input logic [15:0] wd,
                        input exp_t e, input int lat_exp, input logic [N-1:0] en_exp);
    int lat = 0, en_cycles = 0;
    logic [N-1:0] en_seen = '0;
    logic wr_seen = 0;
    logic [15:0] dd = '0;
    sb.push_back(e);
    exp_acks++;
    cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_req = 1;
    do begin
      @(posedge clk); #1;
      lat++;
      if (dev_en != 0) begin
        en_cycles++; en_seen = dev_en; wr_seen = dev_wr_en; dd = dev_data;
      end
    end while (!cpu_ack && lat < 200);
    cpu_req = 0;
    check({n, ".lat"}, lat, lat_exp);
    check({n, ".en"}, en_seen, en_exp);
    check({n, ".en_cycles"}, en_cycles, en_exp != 0 ? 1 : 0);
    if (en_exp != 0) begin
      check({n, ".wr_en"}, wr_seen, we);
      check({n, ".dev_data"}, dd, wd);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int e0 = -1, e1 = -1, a0 = -1, a1 = -1;
    repeat (3) @(posedge clk);
    #1;
    check("rst.busy", cpu_busy, 0);
    check("rst.ack", cpu_ack, 0);
    check("rst.err", cpu_err, 0);
    check("rst.dev_en", dev_en, 0);
    check("rst.wr_en", dev_wr_en, 0);
    check("rst.dev_data", dev_data, 0);
    check("rst.rdata", cpu_rdata, 0);
    rst = 0;
    @(posedge clk); #1;

    access("wr_led", 1, 16'hFF00, 16'h00A5, '{16'h0000, 1'b0}, 2, 4'b0001);
    check("led_reg", regs[0], 16'h00A5);
    access("rd_led", 0, 16'hFF03, 16'h0000, '{16'h00A5, 1'b0}, 2, 4'b0001);

    fork
      begin
        for (int k = 0; k < 50 && !dev_en[1]; k++) @(negedge clk);
        repeat (3) @(posedge clk);
        #1 dev_ready[1] = 1;
      end
    join_none
    access("rd_slow", 0, 16'hFF10, 16'h0000, '{16'h1234, 1'b0}, 5, 4'b0010);

    access("unmap_ff70", 0, 16'hFF70, 16'h0000, '{16'h0000, 1'b0}, 1, 4'b0000);
    access("unmap_1234", 0, 16'h1234, 16'h0000, '{16'h0000, 1'b0}, 1, 4'b0000);
    access("unmap_ff40", 1, 16'hFF40, 16'hBEEF, '{16'h0000, 1'b0}, 1, 4'b0000);
    access("rd_slot3", 0, 16'hFF3F, 16'h0000, '{16'h0F0F, 1'b0}, 2, 4'b1000);

    cpu_we = 0; cpu_addr = 16'hFF20; cpu_req = 1;
    repeat (4) @(posedge clk);
    #1;
    check("wait.busy", cpu_busy, 1);
    rst = 1; cpu_req = 0;
    @(posedge clk); #1;
    check("abort.busy", cpu_busy, 0);
    check("abort.ack", cpu_ack, 0);
    check("abort.dev_en", dev_en, 0);
    rst = 0;
    access("wr_after_rst", 1, 16'hFF00, 16'h00A5, '{16'h0000, 1'b0}, 2, 4'b0001);
    check("led_reg2", regs[0], 16'h00A5);

    sb.push_back('{16'h0000, 1'b0});
    sb.push_back('{16'h0000, 1'b0});
    exp_acks += 2;
    cpu_we = 1; cpu_addr = 16'hFF30; cpu_wdata = 16'h1111; cpu_req = 1;
    for (int k = 1; k <= 10 && a1 < 0; k++) begin
      @(posedge clk); #1;
      if (dev_en != 0) begin
        if (e0 < 0) e0 = k; else e1 = k;
      end
      if (cpu_ack) begin
        if (a0 < 0) a0 = k; else a1 = k;
      end
    end
    cpu_req = 0;
    check("b2b.en0", e0, 1);
    check("b2b.ack0", a0, 2);
    check("b2b.en1", e1, 4);
    check("b2b.ack1", a1, 5);
    check("b2b.reg3", regs[3], 16'h1111);
    @(posedge clk); #1;

`ifdef IO_TIMEOUT_EN
    access("timeout", 0, 16'hFF20, 16'h0000, '{16'hDEAD, 1'b1}, 17, 4'b0100);
`else
    cpu_we = 0; cpu_addr = 16'hFF20; cpu_req = 1;
    repeat (100) @(posedge clk);
    #1;
    check("no_timeout.busy", cpu_busy, 1);
    rst = 1; cpu_req = 0;
    @(posedge clk); #1;
    rst = 0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("acks", acks, exp_acks);
    check("sb_left", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
